// File: rtl/timing_gen_if.sv
// Timing bus between timing_gen (master) and the hard-wired controller (slave).
// The step_i request exists only when STEP_EN is defined.
interface timing_gen_if;
  logic qd_i;
  logic short_i;
  logic long_i;
  logic stop_i;
`ifdef STEP_EN
  logic step_i;
`endif
  logic w1_o;
  logic w2_o;
  logic w3_o;
  logic t3_o;
  logic tick_o;
  logic running_o;

`ifdef STEP_EN
  modport master (
    input  qd_i, short_i, long_i, stop_i, step_i,
    output w1_o, w2_o, w3_o, t3_o, tick_o, running_o
  );
  modport slave (
    output qd_i, short_i, long_i, stop_i, step_i,
    input  w1_o, w2_o, w3_o, t3_o, tick_o, running_o
  );
`else
  modport master (
    input  qd_i, short_i, long_i, stop_i,
    output w1_o, w2_o, w3_o, t3_o, tick_o, running_o
  );
  modport slave (
    output qd_i, short_i, long_i, stop_i,
    input  w1_o, w2_o, w3_o, t3_o, tick_o, running_o
  );
`endif
endinterface

// File: rtl/timing_gen.sv
// Beat/phase timing generator: one-hot W1/W2/W3 beats, t3 and tick phase pulses.
// Define STEP_EN to add single-instruction mode (bus.step_i).
module timing_gen #(
  parameter int PHASES   = 4,
  parameter int T3_PHASE = 2
) (
  input  logic         clk,
  input  logic         clr,
  timing_gen_if.master bus
);

  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
  localparam logic [PW-1:0] T3_IDX     = PW'(T3_PHASE);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    BEAT_NONE = 3'b000,
    BEAT_W1   = 3'b001,
    BEAT_W2   = 3'b010,
    BEAT_W3   = 3'b100
  } beat_e;

  state_e        state_q, state_d;
  beat_e         beat_q, beat_d;
  beat_e         nextBeat;
  logic [PW-1:0] phase_q, phase_d;
  logic          stopPend_q, stopPend_d;
  logic          t3_q, t3_d;
  logic          tick_q, tick_d;
  logic          stepHalt;

  // Beat that follows the current one if the instruction keeps running.
  always_comb begin
    nextBeat = BEAT_W1;
    case (beat_q)
      BEAT_W1: nextBeat = bus.short_i ? BEAT_W1 : BEAT_W2;
      BEAT_W2: nextBeat = bus.long_i  ? BEAT_W3 : BEAT_W1;
      default: nextBeat = BEAT_W1;
    endcase
  end

`ifdef STEP_EN
  assign stepHalt = bus.step_i && (nextBeat == BEAT_W1);
`else
  assign stepHalt = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    phase_d    = phase_q;
    stopPend_d = stopPend_q;
    case (state_q)
      IDLE: begin
        phase_d    = '0;
        stopPend_d = 1'b0;
        beat_d     = BEAT_NONE;
        if (bus.qd_i) begin
          state_d = RUN;
          beat_d  = BEAT_W1;
        end
      end
      RUN: begin
        if (phase_q != LAST_PHASE) begin
          phase_d = phase_q + 1'b1;
          if (bus.stop_i) begin
            stopPend_d = 1'b1;
          end
        end else begin
          // Beat end: a pending or current stop outranks the step boundary.
          phase_d    = '0;
          stopPend_d = 1'b0;
          if (stopPend_q || bus.stop_i || stepHalt) begin
            state_d = IDLE;
            beat_d  = BEAT_NONE;
          end else begin
            beat_d = nextBeat;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = BEAT_NONE;
        phase_d = '0;
      end
    endcase
    t3_d   = (state_d == RUN) && (phase_d == T3_IDX);
    tick_d = (state_d == RUN) && (phase_d == LAST_PHASE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      beat_q     <= BEAT_NONE;
      phase_q    <= '0;
      stopPend_q <= 1'b0;
      t3_q       <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      phase_q    <= phase_d;
      stopPend_q <= stopPend_d;
      t3_q       <= t3_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.w1_o      = beat_q[0];
  assign bus.w2_o      = beat_q[1];
  assign bus.w3_o      = beat_q[2];
  assign bus.t3_o      = t3_q;
  assign bus.tick_o    = tick_q;
  assign bus.running_o = (state_q == RUN);

endmodule

// File: tb/tb_timing_gen.sv
// Self-checking bench for timing_gen: directed beat sequences plus a randomized
// run against an integer-level behavioural model.
module tb_timing_gen;

  localparam int P  = 4;
  localparam int T3 = 2;
`ifdef STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  timing_gen_if bus();

  timing_gen #(.PHASES(P), .T3_PHASE(T3)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model: running flag, beat number 1..3 (0 = none), phase, stop latch.
  bit mRun  = 1'b0;
  int mBeat = 0;
  int mPhase = 0;
  bit mPend = 1'b0;

  function automatic logic [5:0] modelOut();
    return {(mBeat == 1), (mBeat == 2), (mBeat == 3),
            (mRun && mPhase == T3), (mRun && mPhase == P - 1), mRun};
  endfunction

  function automatic logic [5:0] dutOut();
    return {bus.w1_o, bus.w2_o, bus.w3_o, bus.t3_o, bus.tick_o, bus.running_o};
  endfunction

  // Expected output vector for a beat number and phase while running.
  function automatic logic [5:0] runVec(input int beat, input int ph);
    return {(beat == 1), (beat == 2), (beat == 3), (ph == T3), (ph == P - 1), 1'b1};
  endfunction

  // Drive inputs, take one clock, advance the model, settle 1 time unit.
  task automatic applyStimulus(input bit c, input bit q, input bit sh,
                               input bit lg, input bit st, input bit sp);
    int  nb;
    bit  halt;
    clr         = c;
    bus.qd_i    = q;
    bus.short_i = sh;
    bus.long_i  = lg;
    bus.stop_i  = st;
`ifdef STEP_EN
    bus.step_i  = sp;
`endif
    @(posedge clk);
    if (c) begin
      mRun = 0; mBeat = 0; mPhase = 0; mPend = 0;
    end else if (!mRun) begin
      if (q) begin
        mRun = 1; mBeat = 1; mPhase = 0;
      end
    end else if (mPhase < P - 1) begin
      mPhase++;
      if (st) mPend = 1;
    end else begin
      mPhase = 0;
      if (mBeat == 1)      nb = sh ? 1 : 2;
      else if (mBeat == 2) nb = lg ? 3 : 1;
      else                 nb = 1;
      halt = mPend || st || (STEP_ON && sp && nb == 1);
      mPend = 0;
      if (halt) begin
        mRun = 0; mBeat = 0;
      end else begin
        mBeat = nb;
      end
    end
    #1;
  endtask

  task automatic goIdle();
    applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [5:0] got;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 0);
      got = dutOut();
      testsRun++;
      if (got !== 6'b000000) begin
        testsFailed++;
        $display("[TB] FAIL reset clk%0d: got %b, expected %b", i, got, 6'b000000);
      end
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    got = dutOut();
    testsRun++;
    if (got !== 6'b100001) begin
      testsFailed++;
      $display("[TB] FAIL reset_start: got %b, expected %b", got, 6'b100001);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    got = dutOut();
    testsRun++;
    if (got !== 6'b100001) begin
      testsFailed++;
      $display("[TB] FAIL reset_hold: got %b, expected %b", got, 6'b100001);
    end
  endtask

  task automatic test_default();
    logic [5:0] got, exp;
    int b;
    goIdle();
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(0, c == 1, 0, 0, 0, 0);
      b   = ((c - 1) / P) % 2 == 0 ? 1 : 2;
      exp = runVec(b, (c - 1) % P);
      got = dutOut();
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL default c%0d: got %b, expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_long();
    logic [5:0] got, exp;
    int seq[4] = '{1, 2, 3, 1};
    goIdle();
    for (int c = 1; c <= 13; c++) begin
      applyStimulus(0, c == 1, 0, 1, 0, 0);
      exp = runVec(seq[(c - 1) / P], (c - 1) % P);
      got = dutOut();
      testsRun++;
      if (got !== exp || $countones(got[5:3]) > 1) begin
        testsFailed++;
        $display("[TB] FAIL long c%0d: got %b, expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_short();
    logic [5:0] got, exp;
    goIdle();
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(0, c == 1, 1, 0, 0, 0);
      exp = runVec(1, (c - 1) % P);
      got = dutOut();
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL short c%0d: got %b, expected %b", c, got, exp);
      end
    end
  endtask

  task automatic test_stop();
    logic [5:0] got, exp;
    int seqL[3] = '{1, 2, 3};
    goIdle();
    // Stop is high during cycle 5, restart qd during cycle 10.
    for (int c = 1; c <= 11; c++) begin
      applyStimulus(0, (c == 1) || (c == 11), 0, 0, c == 6, 0);
      if (c <= 8)       exp = runVec((c <= 4) ? 1 : 2, (c - 1) % P);
      else if (c <= 10) exp = 6'b000000;
      else              exp = runVec(1, 0);
      got = dutOut();
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL stop c%0d: got %b, expected %b", c, got, exp);
      end
    end
    // clr during cycle 10 (inside W3) forces idle from cycle 11.
    goIdle();
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(c == 11, c == 1, 0, 1, 0, 0);
      exp = (c <= 10) ? runVec(seqL[(c - 1) / P], (c - 1) % P) : 6'b000000;
      got = dutOut();
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL clr_mid c%0d: got %b, expected %b", c, got, exp);
      end
    end
  endtask

`ifdef STEP_EN
  task automatic test_step();
    logic [5:0] got, exp;
    int seqL[3] = '{1, 2, 3};
    goIdle();
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 13; c++) begin
        applyStimulus(0, (r == 0) ? (c == 1) : (c <= 12), 0, 1, 0, 1);
        exp = (c <= 12) ? runVec(seqL[(c - 1) / P], (c - 1) % P) : 6'b000000;
        got = dutOut();
        testsRun++;
        if (got !== exp) begin
          testsFailed++;
          $display("[TB] FAIL step r%0d c%0d: got %b, expected %b", r, c, got, exp);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0] got, exp;
    bit c, q, st, sp, sh, lg;
    sh = 0;
    lg = 0;
    goIdle();
    for (int i = 0; i < 3000; i++) begin
      if (!mRun || mPhase == 0) begin
        sh = ($urandom_range(0, 3) == 0);
        lg = ($urandom_range(0, 1) == 0);
      end
      c  = ($urandom_range(0, 199) == 0);
      q  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 24) == 0);
      sp = ($urandom_range(0, 2) == 0);
      applyStimulus(c, q, sh, lg, st, sp);
      exp = modelOut();
      got = dutOut();
      testsRun++;
      if (got !== exp) begin
        testsFailed++;
        $display("[TB] FAIL random i%0d: got %b, expected %b", i, got, exp);
      end
    end
  endtask

  initial begin
    clr         = 1'b1;
    bus.qd_i    = 1'b0;
    bus.short_i = 1'b0;
    bus.long_i  = 1'b0;
    bus.stop_i  = 1'b0;
`ifdef STEP_EN
    bus.step_i  = 1'b0;
`endif
    test_reset();
    test_default();
    test_long();
    test_short();
    test_stop();
`ifdef STEP_EN
    test_step();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/timing_gen.md
# timing_gen

Beat/phase timing generator that drives the hard-wired controller's timing inputs. It produces the one-hot instruction beats w1/w2/w3 and the per-beat t3 phase pulse. It consumes the controller's sequencing requests short, long and stop, so it sits on the opposite end of that interface. One instance feeds the controller in the teaching-CPU top level.

## Interface
Parameters:
- PHASES, 4, clock cycles per beat; legal range 3..16.
- T3_PHASE, 2, 0-based phase index at which t3 is high; must be < PHASES-1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset; synchronous, active-high.
- qd  input  1  start request; single-cycle or level, sampled each clock.
- short  input  1  from controller: instruction ends after W1.
- long  input  1  from controller: instruction needs W3 after W2.
- stop  input  1  from controller: halt at end of current beat.
- step  input  1  single-instruction mode; present only with STEP_EN.
- w1, w2, w3  output  1 each  one-hot beat indicators; all 0 when idle.
- t3  output  1  phase-3 pulse, high one clock per beat.
- tick  output  1  high on the last clock of every beat (phase PHASES-1).
- running  output  1  high while in RUN.

## Operation
- States: IDLE and RUN. Internal registers: beat (one-hot W1/W2/W3) and phase counter (0..PHASES-1).
- Reset (clr=1 at an edge): state IDLE, phase 0, stop_pend 0. All outputs 0 (w1=w2=w3=t3=tick=running=0). clr overrides every other input, including mid-beat.
- IDLE with qd=1: next clock enters RUN with w1=1, phase=0. qd is ignored while in RUN.
- RUN, phase < PHASES-1: phase increments; beat holds.
- stop_pend is set by any clock in RUN with stop=1. It is cleared on every beat end.
- Beat end (RUN, phase==PHASES-1) sets phase to 0, then applies these rules in priority order:
  - stop_pend or stop is 1: go to IDLE, all w cleared.
  - W1: short ? W1 : W2.
  - W2: long ? W3 : W1.
  - W3: W1.
- short and long are sampled only on the beat-end clock. The controller holds them stable for the whole beat.
- t3 = running && phase==T3_PHASE. tick = running && phase==PHASES-1. Both are decoded from registers, with no combinational path from any input.
- Simultaneous stop and qd at beat end: stop wins. qd on the following IDLE clock restarts at W1.

## Timing
- Start latency: qd sampled at edge N gives w1=1 from edge N+1.
- Each beat lasts exactly PHASES clocks. t3 is high in cycle T3_PHASE of each beat.
- Stop latency: halt takes effect at the first beat end on or after stop. Outputs are 0 one clock after that beat-end edge.
- Instruction length: short gives 1 beat, default gives 2 beats, long gives 3 beats.
- phase never exceeds PHASES-1. It wraps to 0 at every beat end, including the transition to IDLE.

## Configuration
- STEP_EN defined: adds input step. With step=1 at a beat end whose next beat would be W1 (instruction boundary), the generator goes to IDLE instead. Each qd then runs exactly one instruction. stop still has priority. step=0 behaves as the base design.
- STEP_EN undefined: no step port; free-running until stop or clr.

## Test plan
Default parameters (PHASES=4, T3_PHASE=2); cycle 1 = first clock after qd edge.
- Reset: clr=1 for 2 clocks with qd=1 -> all outputs 0, running=0. Release clr, pulse qd -> w1=1 next clock.
- Default instruction (short=long=stop=0): w1 in cycles 1-4, w2 in 5-8, w1 again from 9. t3 high in cycles 3, 7, 11. tick high in 4, 8, 12.
- long=1 during W2: beat sequence W1(1-4), W2(5-8), W3(9-12), W1(13). w1/w2/w3 are never simultaneously high.
- short=1 held: w1 stays high for 12 clocks, w2 never asserts, t3 pulses in cycles 3, 7, 11.
- Stop: 1-clock stop pulse in cycle 5 (W2 phase 0) -> W2 completes through cycle 8, then cycle 9 is idle with all outputs 0. qd in cycle 10 restarts w1 in cycle 11. clr asserted in cycle 10 of a W3 beat -> idle from cycle 11.
- STEP_EN with step=1, long=1: one qd yields W1, W2, W3 (12 clocks) then idle. A second qd repeats the sequence. A qd held during RUN has no effect.
